// File: rtl/random_number_gen_if.sv
// Request/sample handshake bundle for random_number_gen.
//   req     : request one sample (honoured only while the generator is idle)
//   load    : load seed into the LFSR on this edge
//   seed    : seed value used with load (0 is remapped to 1)
//   offset  : add the configured offset to every candidate
//   busy    : high while a draw is in progress
//   valid   : one-cycle pulse when data is updated
//   data    : last accepted sample, held between pulses
//   clamped : qualifies valid; data was forced to the limit
interface random_number_gen_if #(
    parameter int WIDTH  = 10,
    parameter int DATA_W = 10
);
    logic              req;
    logic              load;
    logic [WIDTH-1:0]  seed;
    logic              offset;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              clamped;

    modport master (
        output req, load, seed, offset,
        input  busy, valid, data, clamped
    );

    modport slave (
        input  req, load, seed, offset,
        output busy, valid, data, clamped
    );
endinterface

// File: rtl/random_number_gen.sv
// Pseudo-random sample source: a free-running Fibonacci LFSR feeds a
// scaled/offset candidate that is accepted when it does not exceed LIMIT.
// Rejected candidates are redrawn on following cycles; after MAX_TRIES
// rejections the output clamps to LIMIT and clamped is raised.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : random_number_gen_if slave (req/load/seed/offset in,
//           busy/valid/data/clamped out)
//
// state | meaning
// IDLE  | waiting for req; LFSR free-runs
// DRAW  | evaluating one candidate per cycle until accept or clamp
module random_number_gen #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] TAPS       = 10'h240,
    parameter logic [WIDTH-1:0] RESET_SEED = 10'd1,
    parameter int               SAMPLE_W   = 8,
    parameter int               SHIFT      = 2,
    parameter int               OFFSET     = 300,
    parameter int               DATA_W     = 10,
    parameter int               LIMIT      = 1023,
    parameter int               MAX_TRIES  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    random_number_gen_if.slave   bus
);

    // Two guard bits above DATA_W keep the shifted+offset candidate exact.
    localparam int CAND_W = DATA_W + 2;
    localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {IDLE, DRAW} fsm_t;

    fsm_t              fsm_q,     fsm_d;
    logic [WIDTH-1:0]  state_q,   state_d;
    logic [TRY_W-1:0]  try_q,     try_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              valid_q,   valid_d;
    logic              clamped_q, clamped_d;
    logic              busy_q,    busy_d;

    logic [WIDTH-1:0]  state_adv;
    logic [CAND_W-1:0] cand;
    logic              accept;

    always_comb begin
        state_adv = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        // A zero seed would lock the LFSR up, so it is remapped to 1.
        if (bus.load)
            state_d = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
        else
            state_d = state_adv;
    end

    always_comb begin
        cand   = (CAND_W'(state_q[SAMPLE_W-1:0]) << SHIFT)
               + (bus.offset ? CAND_W'(OFFSET) : '0);
        accept = (cand <= CAND_W'(LIMIT));
    end

    always_comb begin
        fsm_d     = fsm_q;
        try_d     = try_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        clamped_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.req) begin
                    fsm_d = DRAW;
                    try_d = '0;
                end
            end
            DRAW: begin
                if (accept) begin
                    data_d  = cand[DATA_W-1:0];
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end else if (try_q == LAST_TRY) begin
                    data_d    = DATA_W'(LIMIT);
                    valid_d   = 1'b1;
                    clamped_d = 1'b1;
                    fsm_d     = IDLE;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d == DRAW);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q     <= IDLE;
            state_q   <= RESET_SEED;
            try_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            try_q     <= try_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clamped_q <= clamped_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
    assign bus.data    = data_q;
    assign bus.clamped = clamped_q;

endmodule

// File: doc/random_number_gen.md
Name: random_number_gen

Overview:
- Parametrised pseudo-random number source for game logic (spawn positions, timing jitter).
- Free-running Fibonacci LFSR of configurable width and taps.
- Request/valid handshake returns one scaled, offset, range-limited sample per request.
- Out-of-range candidates are redrawn by rejection sampling; after MAX_TRIES rejections the output clamps to LIMIT and a flag is raised.

Parameters:
WIDTH, 10, LFSR state width (>=3)
TAPS, 10'h240, feedback tap mask; bit i set means state[i] is XORed into feedback (default x^10+x^7+1, period 1023)
RESET_SEED, 1, state value on reset; must be nonzero
SAMPLE_W, 8, number of low state bits used for a sample (<=WIDTH)
SHIFT, 2, left shift applied to the sample
OFFSET, 300, added to the candidate when offset=1
DATA_W, 10, output width
LIMIT, 1023, maximum accepted value (<=2^DATA_W-1)
MAX_TRIES, 4, rejections allowed before clamping (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  request one sample; honoured only in IDLE
load  in  1  load seed into the LFSR this edge
seed  in  WIDTH  seed value used with load
offset  in  1  add OFFSET to candidates; sampled every DRAW cycle
busy  out  1  high while in DRAW
valid  out  1  one-cycle pulse when data is updated
data  out  DATA_W  last accepted sample; holds between pulses
clamped  out  1  qualifies the valid pulse; 1 when data was forced to LIMIT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RESET_SEED, FSM=IDLE, try count=0.
  - data=0, valid=0, busy=0, clamped=0.
- LFSR advances on every clock edge in every FSM state.
  - next = {state[WIDTH-2:0], ^(state & TAPS)}.
- load=1 overrides the advance: state<=seed. If seed==0, state<=1 (lock-up guard).
  - Load is legal in any state. A draw in progress continues from the loaded state.
- Candidate (combinational, DATA_W+2 bits, no truncation):
  - cand = (state[SAMPLE_W-1:0] << SHIFT) + (offset ? OFFSET : 0).
  - Accept when cand <= LIMIT; otherwise reject.
- FSM IDLE:
  - req=1 -> DRAW, try count=0. busy rises on the same edge.
  - req and load in the same cycle: the load takes effect and the draw starts from the seed.
- FSM DRAW, each cycle, evaluated on the current state:
  - Accept: data<=cand[DATA_W-1:0], valid=1, clamped=0, go to IDLE.
  - Reject with try count < MAX_TRIES-1: increment try count, stay in DRAW.
  - Reject with try count == MAX_TRIES-1: data<=LIMIT, valid=1, clamped=1, go to IDLE.
- Latency: req at edge N; first possible valid is registered at edge N+2 (high in cycle N+2). Worst case is N+1+MAX_TRIES.
- valid and clamped are registered outputs. Both are 0 in every cycle without an update.
- req while busy is ignored, not queued. A req in the valid cycle is accepted, since the FSM is already in IDLE.
- Reset mid-draw aborts the draw immediately: no valid pulse, data returns to 0.
- State is never 0 with legal parameters.

Test Plan:
- Reset, no stimulus -> data=0, valid=0, busy=0. State sequence from 0x001 is 0x002, 0x004 … 0x040, then 0x081 on the 7th advance.
- Pulse load with seed=0x001, then free-run 1023 cycles -> state returns to 0x001. All 1023 nonzero values appear once; 0 never appears.
- Pulse load with seed=0x000 -> next state 0x001; later states follow the sequence above.
- In IDLE, assert load with seed=0x050, req=1, offset=0 -> busy=1 next cycle; valid high 2 cycles after req with data=320, clamped=0.
- Load seed=0x0FF with req, offset=1 -> four rejections (states 0x0FF, 0x1FF, 0x3FF, 0x3FE; candidates 1320, 1320, 1320, 1316). Then valid with data=1023, clamped=1, 5 cycles after req.
- Negative cases:
  - req during DRAW -> no extra valid.
  - reset=0 mid-draw -> no valid; data=0; after release, state=RESET_SEED.
